// File: rtl/ripple_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ripple_add_sequencer_pkg
// Shared definitions for the nibble-serial adder/subtractor:
//   - state_t : sequencer FSM encoding (IDLE / RUN / DONE), 2 bits
//   - SLICE_W : width of the ripple-carry datapath slice (4 bits)
//   - ovf_of  : signed-overflow rule applied to the final slice
// ---------------------------------------------------------------------------
package ripple_add_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: both operands share a sign and the result
  // sign differs from it. b_msb is the sign of the (possibly inverted) B.
  function automatic logic ovf_of(input logic a_msb,
                                  input logic b_msb,
                                  input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/ripple_add_sequencer_ripple_carryadder.sv
// ---------------------------------------------------------------------------
// ripple_carryadder
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b  [3:0] in  : addends
//   cin         in  : carry into bit 0
//   s     [3:0] out : a + b + cin (low 4 bits)
//   cout        out : carry out of bit 3
// ---------------------------------------------------------------------------
module ripple_carryadder
  import ripple_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/ripple_add_sequencer.sv
// ---------------------------------------------------------------------------
// ripple_add_sequencer
// Multi-cycle WIDTH-bit adder/subtractor built on one 4-bit ripple slice.
// Operands are captured through a valid/ready handshake, processed one
// nibble per cycle (LSB first) with the carry held in a register, and the
// assembled result is offered through a valid/ready output handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready high only in IDLE)
//   a, b [WIDTH-1:0]  : operands, sampled only at the capture edge
//   cin               : carry-in for add; ignored when sub=1
//   sub               : 1 computes a-b
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum [WIDTH-1:0]   : result, stable while out_valid=1
//   cout              : carry out of MSB (subtract: 1 = no borrow)
//   ovf               : signed overflow
// ---------------------------------------------------------------------------
module ripple_add_sequencer
  import ripple_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("ripple_add_sequencer: WIDTH must be a positive multiple of 4");
  end

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    carry;
  logic signed [WIDTH-1:0] a_r;
  logic signed [WIDTH-1:0] b_r;
  logic                    a_msb;
  logic                    b_msb;
  logic [WIDTH-1:0]        sum_r;
  logic                    cout_r;
  logic                    ovf_r;
  logic                    in_ready_r;
  logic                    out_valid_r;

  logic signed [WIDTH-1:0] b_eff;
  logic [SLICE_W-1:0]      nib_a;
  logic [SLICE_W-1:0]      nib_b;
  logic [SLICE_W-1:0]      slice_s;
  logic                    slice_co;
  logic                    last;

  // Subtraction is a + ~b + 1; the +1 enters through the carry register.
  assign b_eff = sub ? signed'(~b) : signed'(b);

  assign nib_a = a_r[int'(idx) * SLICE_W +: SLICE_W];
  assign nib_b = b_r[int'(idx) * SLICE_W +: SLICE_W];
  assign last  = (idx == LAST_IDX);

  ripple_carryadder u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        // Capture stage: latch operands, effective B and initial carry
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= signed'(a);
            b_r        <= b_eff;
            carry      <= sub ? 1'b1 : cin;
            a_msb      <= a[WIDTH-1];
            b_msb      <= b_eff[WIDTH-1];
            sum_r      <= '0;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= ST_RUN;
          end
        end

        // Slice stage: one nibble per cycle, carry chained through register
        ST_RUN: begin
          sum_r[int'(idx) * SLICE_W +: SLICE_W] <= slice_s;
          carry <= slice_co;
          if (last) begin
            idx         <= '0;
            cout_r      <= slice_co;
            ovf_r       <= ovf_of(a_msb, b_msb, slice_s[SLICE_W-1]);
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // Output stage: hold result until the consumer takes it
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          idx         <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
